// File: rtl/ysyx_22050243_mul_pkg.sv
// Shared definitions for the multiply sequencer: op codes, FSM states,
// decoded-op bundle and a small sign-extension helper.
package ysyx_22050243_mul_pkg;

    // RV64M multiply op codes as presented by the EXU issue stage
    localparam logic [2:0] MUL_OP_MUL    = 3'd0;
    localparam logic [2:0] MUL_OP_MULH   = 3'd1;
    localparam logic [2:0] MUL_OP_MULHSU = 3'd2;
    localparam logic [2:0] MUL_OP_MULHU  = 3'd3;
    localparam logic [2:0] MUL_OP_MULW   = 3'd4;

    // Sequencer states
    typedef enum logic [2:0] {
        MULC_IDLE  = 3'd0,
        MULC_START = 3'd1,
        MULC_WAIT  = 3'd2,
        MULC_RESP  = 3'd3,
        MULC_DRAIN = 3'd4
    } mulc_state_t;

    // Handshake-to-out_valid latency of a request that runs the multiplier
    localparam int MUL_LAT = 36;

    // What an op code means to the multiplier and to the result mux
    typedef struct packed {
        logic xs;        // multiplicand signed
        logic ys;        // multiplier signed
        logic sel_high;  // return product[127:64]
        logic sext32;    // word op: sext operands and result from bit 31
        logic illegal;   // unknown op: answer 0, never start the multiplier
    } mul_dec_t;

    function automatic logic [63:0] sext_w(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050243_mul_ctrl_if.sv
// Request/response channel between the EXU issue stage and the multiply
// sequencer. The issue side is the master, the sequencer the slave.
interface ysyx_22050243_mul_ctrl_if #(
    parameter int ID_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [63:0]     in_src1;
    logic [63:0]     in_src2;
    logic [ID_W-1:0] in_id;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_result;
    logic [ID_W-1:0] out_id;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_id, flush, out_ready,
        input  in_ready, out_valid, out_result, out_id
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_id, flush, out_ready,
        output in_ready, out_valid, out_result, out_id
    );
endinterface

// File: rtl/ysyx_22050243_mul_opdec.sv
// Combinational op decoder: turns a 3-bit multiply op into operand sign
// controls and result-selection flags.
module ysyx_22050243_mul_opdec
    import ysyx_22050243_mul_pkg::*;
(
    input  logic [2:0] op,
    output mul_dec_t   dec
);

    // MUL shares the signed/signed setting of MULH so a MULH+MUL pair on the
    // same operands hits the product cache.
    always_comb begin
        dec = '{xs: 1'b1, ys: 1'b1, sel_high: 1'b0, sext32: 1'b0, illegal: 1'b0};
        case (op)
            MUL_OP_MUL:    ;
            MUL_OP_MULH:   dec.sel_high = 1'b1;
            MUL_OP_MULHSU: begin
                dec.ys       = 1'b0;
                dec.sel_high = 1'b1;
            end
            MUL_OP_MULHU:  begin
                dec.xs       = 1'b0;
                dec.ys       = 1'b0;
                dec.sel_high = 1'b1;
            end
            MUL_OP_MULW:   dec.sext32 = 1'b1;
            default:       dec = '{xs: 1'b0, ys: 1'b0, sel_high: 1'b0, sext32: 1'b0, illegal: 1'b1};
        endcase
    end

endmodule

// File: rtl/ysyx_22050243_mul_ctrl.sv
// Sequencer between the EXU issue stage and the iterative Booth multiplier.
// Accepts one request at a time, starts the multiplier unless the last
// product can be reused, and returns the selected result over valid/ready.
module ysyx_22050243_mul_ctrl
    import ysyx_22050243_mul_pkg::*;
#(
    parameter int ID_W     = 4,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22050243_mul_ctrl_if.slave io,
    output logic                    busy,
    output logic [63:0]             mul_x,
    output logic [63:0]             mul_y,
    output logic                    mul_xs,
    output logic                    mul_ys,
    output logic                    mul_type,
    output logic                    mul_stuck,
    input  logic [63:0]             mul_high,
    input  logic [63:0]             mul_low,
    input  logic                    mul_ready
);

    mulc_state_t     state_reg;
    mul_dec_t        dec_now;
    mul_dec_t        dec_reg;
    logic [63:0]     x_new;
    logic [63:0]     y_new;
    logic [63:0]     x_reg;
    logic [63:0]     y_reg;
    logic [ID_W-1:0] id_reg;
    logic [129:0]    key_new;
    logic [129:0]    cache_key_reg;
    logic            cache_vld_reg;
    logic            accept;
    logic            hit;
    logic [63:0]     result_mux;

    ysyx_22050243_mul_opdec u_opdec (
        .op  (io.in_op),
        .dec (dec_now)
    );

    // Word ops see operands sign-extended from bit 31; the low half passes through.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_opnd
            if (gi < 32) begin : g_lo
                assign x_new[gi] = io.in_src1[gi];
                assign y_new[gi] = io.in_src2[gi];
            end else begin : g_hi
                assign x_new[gi] = dec_now.sext32 ? io.in_src1[31] : io.in_src1[gi];
                assign y_new[gi] = dec_now.sext32 ? io.in_src2[31] : io.in_src2[gi];
            end
        end
    endgenerate

    // The cache key is what the multiplier actually sees, so MULW and MUL on
    // equal extended operands share a product.
    assign key_new = {x_new, y_new, dec_now.xs, dec_now.ys};
    assign hit     = CACHE_EN && cache_vld_reg && (key_new == cache_key_reg);

    assign io.in_ready  = (state_reg == MULC_IDLE) && !io.flush;
    assign accept       = io.in_valid && io.in_ready;
    assign io.out_valid = (state_reg == MULC_RESP) && !io.flush;
    assign io.out_id    = id_reg;
    assign busy         = (state_reg != MULC_IDLE);
    assign mul_x        = x_reg;
    assign mul_y        = y_reg;
    assign mul_xs       = dec_reg.xs;
    assign mul_ys       = dec_reg.ys;
    assign mul_type     = (state_reg == MULC_START);
    assign mul_stuck    = (state_reg == MULC_RESP);

    // Result selection from the product the multiplier holds while stuck
    always_comb begin
        result_mux = mul_low;
        if (dec_reg.illegal) begin
            result_mux = '0;
        end else if (dec_reg.sel_high) begin
            result_mux = mul_high;
        end else if (dec_reg.sext32) begin
            result_mux = sext_w(mul_low[31:0]);
        end
    end
    assign io.out_result = result_mux;

    // Request sequencing, operand/tag capture and product-cache bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= MULC_IDLE;
            cache_vld_reg <= 1'b0;
            cache_key_reg <= '0;
            dec_reg       <= '0;
            id_reg        <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
        end else begin
            case (state_reg)
                MULC_IDLE: begin
                    if (accept) begin
                        dec_reg <= dec_now;
                        id_reg  <= io.in_id;
                        x_reg   <= x_new;
                        y_reg   <= y_new;
                        if (dec_now.illegal || hit) begin
                            state_reg <= MULC_RESP;
                        end else begin
                            state_reg <= MULC_START;
                        end
                    end
                end
                MULC_START: begin
                    // The product being overwritten is no longer reusable
                    cache_vld_reg <= 1'b0;
                    cache_key_reg <= {x_reg, y_reg, dec_reg.xs, dec_reg.ys};
                    state_reg     <= io.flush ? MULC_DRAIN : MULC_WAIT;
                end
                MULC_WAIT: begin
                    if (io.flush) begin
                        state_reg <= MULC_DRAIN;
                    end else if (mul_ready) begin
                        cache_vld_reg <= 1'b1;
                        state_reg     <= MULC_RESP;
                    end
                end
                MULC_RESP: begin
                    if (io.flush || io.out_ready) begin
                        state_reg <= MULC_IDLE;
                    end
                end
                MULC_DRAIN: begin
                    // The multiplier cannot abort; let it finish, keep the product
                    if (mul_ready) begin
                        cache_vld_reg <= 1'b1;
                        state_reg     <= MULC_IDLE;
                    end
                end
                default: state_reg <= MULC_IDLE;
            endcase
        end
    end

endmodule
